// File: rtl/scan_chain_driver.sv
// Scan chain driver: shifts a word into a CHAIN_LEN-bit scan chain while capturing the word shifted out.
// Optional compare of the captured word against an expected word: define SCAN_CHAIN_DRIVER_CMP_EN.
module scan_chain_driver #(
  parameter int CHAIN_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] wr_data,
  output logic [CHAIN_LEN-1:0] rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 scan_enable,
  output logic                 chain_si,
  input  logic                 chain_so
`ifdef SCAN_CHAIN_DRIVER_CMP_EN
  ,
  input  logic [CHAIN_LEN-1:0] exp_data,
  output logic                 mismatch
`endif
);

  localparam int CNT_W = (CHAIN_LEN > 2) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] shreg;
  logic [CHAIN_LEN-1:0] shreg_shifted;

  assign shreg_shifted = {chain_so, shreg[CHAIN_LEN-1:1]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The unused encoding falls into the default arm and returns to IDLE.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = start ? SHIFT : IDLE;
      SHIFT:   state_next = (cnt == CNT_LAST) ? DONE : SHIFT;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // rd_data is captured on the edge entering DONE so it is already valid while done is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      shreg   <= '0;
      rd_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= wr_data;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          shreg <= shreg_shifted;
          if (cnt == CNT_LAST) begin
            rd_data <= shreg_shifted;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SCAN_CHAIN_DRIVER_CMP_EN
  logic [CHAIN_LEN-1:0] exp_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      exp_q    <= '0;
      mismatch <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        exp_q <= exp_data;
      end
      if (state == SHIFT && cnt == CNT_LAST) begin
        mismatch <= (shreg_shifted != exp_q);
      end
    end
  end
`endif

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign scan_enable = (state == SHIFT);
  assign chain_si    = (state == SHIFT) & shreg[0];

endmodule

// File: tb/tb_scan_chain_driver.sv
// Directed bench for scan_chain_driver with an 8-bit behavioural scan chain on its pins.
module tb_scan_chain_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;
  logic       scan_enable;
  logic       chain_si;
  logic       chain_so;
`ifdef SCAN_CHAIN_DRIVER_CMP_EN
  logic [7:0] exp_data;
  logic       mismatch;
`endif

  logic [7:0] q;
  logic [7:0] load_val;
  logic       load;

  int vectors     = 0;
  int miscompares = 0;
  int done_seen   = 0;
  int cyc         = 0;

  always #5 clk = ~clk;

  scan_chain_driver #(.CHAIN_LEN(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .busy        (busy),
    .done        (done),
    .scan_enable (scan_enable),
    .chain_si    (chain_si),
    .chain_so    (chain_so)
`ifdef SCAN_CHAIN_DRIVER_CMP_EN
    ,
    .exp_data    (exp_data),
    .mismatch    (mismatch)
`endif
  );

  // Behavioural chain: shifts toward bit 0 while scan_enable is high.
  always @(posedge clk) begin
    if (load) q <= load_val;
    else if (scan_enable) q <= {chain_si, q[7:1]};
  end
  assign chain_so = q[0];

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
    if (done === 1'b1) done_seen++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] v);
    load_val = v;
    load = 1'b1;
    tick;
    load = 1'b0;
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (done === 1'b1) begin
        at = cyc;
        break;
      end
    end
    chk("done_within_bound", 32'(at >= 0), 32'd1);
  endtask

  initial begin
    logic [7:0] w;
    int d0, d1, a1, a2;
    rst = 1'b0; start = 1'b1; wr_data = 8'hFF; load = 1'b0; load_val = 8'h00;
`ifdef SCAN_CHAIN_DRIVER_CMP_EN
    exp_data = 8'h00;
`endif

    // Reset held with start high
    tick; tick;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_se", 32'(scan_enable), 32'd0);
    chk("rst_si", 32'(chain_si), 32'd0);
    chk("rst_rd", 32'(rd_data), 32'h00);
    start = 1'b0; rst = 1'b1;
    tick;
    chk("post_rst_idle", 32'(busy), 32'd0);

    // Basic transaction: chain 0x3C, write 0xA5
    preload(8'h3C);
    w = 8'hA5; wr_data = w; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t1_se", 32'(scan_enable), 32'd1);
      chk("t1_si", 32'(chain_si), 32'(w[i]));
      chk("t1_nodone", 32'(done), 32'd0);
      tick;
    end
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy_done", 32'(busy), 32'd1);
    chk("t1_se_done", 32'(scan_enable), 32'd0);
    chk("t1_si_done", 32'(chain_si), 32'd0);
    tick;
    chk("t1_done_single", 32'(done), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_rd", 32'(rd_data), 32'h3C);
    chk("t1_chain", 32'(q), 32'hA5);

    // Starts during SHIFT and DONE are dropped; chain holds 0xA5
    wr_data = 8'h5A; d0 = done_seen; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("ign_busy", 32'(busy), 32'd1);
    chk("ign_se", 32'(scan_enable), 32'd1);
    for (int i = 0; i < 5; i++) tick;
    chk("ign_done", 32'(done), 32'd1);
    start = 1'b1;
    tick;
    chk("ign_not_queued", 32'(busy), 32'd0);
    chk("ign_rd", 32'(rd_data), 32'hA5);
    tick;
    start = 1'b0;
    chk("ign_accept_next", 32'(busy), 32'd1);
    chk("ign_one_done", 32'(done_seen - d0), 32'd1);

    // Reset four edges into the shift
    tick; tick; tick;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    chk("mid_rst_se", 32'(scan_enable), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rd", 32'(rd_data), 32'h00);
    d1 = done_seen;
    for (int i = 0; i < 12; i++) tick;
    chk("mid_rst_no_done", 32'(done_seen - d1), 32'd0);

    // Back-to-back with start held
    preload(8'h3C);
    wr_data = 8'hA5; start = 1'b1;
    wait_done(a1);
    tick;
    chk("b2b_rd1", 32'(rd_data), 32'h3C);
    wait_done(a2);
    start = 1'b0;
    chk("b2b_period", 32'(a2 - a1), 32'd10);
    tick;
    chk("b2b_rd2", 32'(rd_data), 32'hA5);

`ifdef SCAN_CHAIN_DRIVER_CMP_EN
    tick;
    preload(8'h3C);
    exp_data = 8'h3C; wr_data = 8'h00; start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(a1);
    tick;
    chk("cmp_match", 32'(mismatch), 32'd0);
    preload(8'h3C);
    exp_data = 8'h3D; start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(a1);
    tick;
    chk("cmp_mismatch", 32'(mismatch), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scan_chain_driver.md
SCAN_CHAIN_DRIVER -- requirements
Module: scan_chain_driver

Interface
REQ-001 Parameter CHAIN_LEN, default 8, legal range 2..64; sets the scan chain length in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to start one scan transaction; sampled only in IDLE.
REQ-005 wr_data  input  CHAIN_LEN  word to shift into the chain; captured on the accepted start.
REQ-006 rd_data  output  CHAIN_LEN  word shifted out of the chain; holds its value until the next DONE.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 done  output  1  single-cycle pulse marking completion of a transaction.
REQ-009 scan_enable  output  1  drives the chain's scan_enable.
REQ-010 chain_si  output  1  drives the chain's scan_in.
REQ-011 chain_so  input  1  driven by the chain's scan_out.

Function
REQ-012 FSM states: IDLE, SHIFT, DONE; state register only, outputs decoded from registered state.
REQ-013 IDLE with start=1: load shift register with wr_data, clear bit counter, enter SHIFT next cycle.
REQ-014 IDLE with start=0: remain IDLE.
REQ-015 SHIFT: scan_enable=1, chain_si=shreg[0]; each cycle shreg <= {chain_so, shreg[CHAIN_LEN-1:1]}, counter +1.
REQ-016 SHIFT lasts exactly CHAIN_LEN cycles; counter==CHAIN_LEN-1 -> DONE; counter width ceil(log2(CHAIN_LEN)) bits, no wrap.
REQ-017 DONE: rd_data <= shreg; done=1, busy=1, scan_enable=0 for one cycle; next state IDLE unconditionally.
REQ-018 Bit order: rd_data[k] = chain_so sampled in SHIFT cycle k; wr_data[0] is presented first on chain_si.
REQ-019 Latency: start accepted at edge t -> SHIFT covers cycles t+1..t+CHAIN_LEN -> done high in cycle t+CHAIN_LEN+1.
REQ-020 start while busy=1, including during DONE, is ignored and not queued; start held high re-triggers in the first IDLE cycle.
REQ-021 scan_enable and chain_si are 0 outside SHIFT.
REQ-022 Illegal state encodings return to IDLE on the next edge.

Reset
REQ-023 rst=0 at a rising edge: state=IDLE, counter=0, shreg=0, rd_data=0; busy, done, scan_enable, chain_si all 0 from the next cycle.
REQ-024 Reset during SHIFT or DONE aborts the transaction: no done pulse, rd_data cleared; chain contents are left partially shifted and are not restored.
REQ-025 Reset has priority over start in the same cycle.

Configuration
REQ-026 Macro SCAN_CHAIN_DRIVER_CMP_EN defined: add input exp_data (CHAIN_LEN) and output mismatch (1).
REQ-027 With SCAN_CHAIN_DRIVER_CMP_EN: exp_data is latched on the accepted start; on entering DONE, mismatch <= (captured word != latched exp_data); mismatch holds until the next DONE and is cleared by reset.
REQ-028 Without SCAN_CHAIN_DRIVER_CMP_EN: the exp_data and mismatch ports and all compare logic are absent; all other behaviour is identical.

Verification
Chain model for all scenarios: CHAIN_LEN=8; 8-bit register, shifts {si, q[7:1]} when scan_enable=1; so=q[0].
REQ-029 Reset: hold rst=0 for 2 cycles with start=1 -> busy, done, scan_enable, chain_si, rd_data all 0; no transaction starts.
REQ-030 Basic transaction: model preloaded 0x3C, wr_data=0xA5, start at t -> scan_enable high exactly cycles t+1..t+8; done pulse at t+9; rd_data=0x3C; model holds 0xA5.
REQ-031 Busy ignore: start pulses at t+3 and at t+9 (DONE cycle) -> exactly one transaction and one done pulse; a start at t+10 is accepted.
REQ-032 Reset mid-shift: rst=0 at t+4 -> scan_enable=0 and busy=0 from t+5; no done pulse; rd_data=0x00.
REQ-033 Back-to-back: start held high continuously -> transactions at an 10-cycle period; the second rd_data equals the chain contents written by the first (0xA5).
REQ-034 Compare (SCAN_CHAIN_DRIVER_CMP_EN defined): model 0x3C, exp_data=0x3C -> mismatch=0; repeat with exp_data=0x3D -> mismatch=1 after that transaction's done.
